// File: rtl/mem_stage_module.sv
// Memory stage: word-addressed data memory with configurable wait states, a stall
// request while an access is in flight, and the MEM/WB pipeline register.
module mem_stage_module #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_en_in,
  input  logic        mem_r_en_in,
  input  logic        mem_w_en_in,
  input  logic [31:0] alu_res_in,
  input  logic [31:0] val_r_m_in,
  input  logic [3:0]  dest_in,
  output logic        freeze,
  output logic        wb_en_out,
  output logic        mem_r_en_out,
  output logic [31:0] alu_res_out,
  output logic [31:0] mem_data_out,
  output logic [3:0]  dest_out
);

  localparam int unsigned AddrW   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  WaitCnt = 4'(WAIT_CYCLES);
  localparam logic        NoWait  = (WAIT_CYCLES == 0);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] mem_q [DEPTH_WORDS];

  logic             acc, complete, in_range, do_write;
  logic [31:0]      idx, rd_data;
  logic [AddrW-1:0] word_idx;

  logic        wb_en_q, wb_en_d;
  logic        mem_r_en_q, mem_r_en_d;
  logic [31:0] alu_res_q, alu_res_d;
  logic [31:0] mem_data_q, mem_data_d;
  logic [3:0]  dest_q, dest_d;

  // Underflow below BASE_ADDR wraps to a huge index and lands out of range.
  always_comb begin
    acc      = mem_r_en_in | mem_w_en_in;
    idx      = (alu_res_in - BASE_ADDR) >> 2;
    in_range = (idx < DEPTH_WORDS);
    word_idx = idx[AddrW-1:0];
    rd_data  = in_range ? mem_q[word_idx] : 32'd0;
    complete = acc & (NoWait | ((state_q == StWait) & (cnt_q == WaitCnt)));
    freeze   = acc & ~complete;
    do_write = complete & mem_w_en_in & in_range;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (acc && !NoWait) begin
          state_d = StWait;
          cnt_d   = 4'd1;
        end
      end
      StWait: begin
        // A dropped request aborts the access without writing.
        if (!acc || (cnt_q == WaitCnt)) begin
          state_d = StIdle;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Frozen cycles insert a bubble; payload fields simply hold.
  always_comb begin
    wb_en_d    = 1'b0;
    mem_r_en_d = 1'b0;
    alu_res_d  = alu_res_q;
    mem_data_d = mem_data_q;
    dest_d     = dest_q;
    if (!freeze) begin
      wb_en_d    = wb_en_in;
      mem_r_en_d = mem_r_en_in;
      alu_res_d  = alu_res_in;
      mem_data_d = mem_r_en_in ? rd_data : 32'd0;
      dest_d     = dest_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      wb_en_q    <= 1'b0;
      mem_r_en_q <= 1'b0;
      alu_res_q  <= 32'd0;
      mem_data_q <= 32'd0;
      dest_q     <= 4'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wb_en_q    <= wb_en_d;
      mem_r_en_q <= mem_r_en_d;
      alu_res_q  <= alu_res_d;
      mem_data_q <= mem_data_d;
      dest_q     <= dest_d;
    end
  end

  // Memory contents survive reset; reset only suppresses a pending write.
  always_ff @(posedge clk) begin
    if (!rst && do_write) begin
      mem_q[word_idx] <= val_r_m_in;
    end
  end

  assign wb_en_out    = wb_en_q;
  assign mem_r_en_out = mem_r_en_q;
  assign alu_res_out  = alu_res_q;
  assign mem_data_out = mem_data_q;
  assign dest_out     = dest_q;

endmodule

// File: tb/tb_mem_stage_module.sv
// Scoreboard bench for mem_stage_module: a default (2 wait state) instance and a
// zero-wait instance, directed vectors with hand-computed expected results.
module tb_mem_stage_module;

  typedef struct packed {
    logic        wb;
    logic        rd;
    logic [31:0] alu;
    logic [31:0] data;
    logic [3:0]  dest;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        wb_en_in, mem_r_en_in, mem_w_en_in;
  logic [31:0] alu_res_in, val_r_m_in;
  logic [3:0]  dest_in;
  logic        freeze, wb_en_out, mem_r_en_out;
  logic [31:0] alu_res_out, mem_data_out;
  logic [3:0]  dest_out;

  logic        z_wb_en_in, z_mem_r_en_in, z_mem_w_en_in;
  logic [31:0] z_alu_res_in, z_val_r_m_in;
  logic [3:0]  z_dest_in;
  logic        z_freeze, z_wb_en_out, z_mem_r_en_out;
  logic [31:0] z_alu_res_out, z_mem_data_out;
  logic [3:0]  z_dest_out;

  mem_stage_module u_dut (
    .clk          (clk),
    .rst          (rst),
    .wb_en_in     (wb_en_in),
    .mem_r_en_in  (mem_r_en_in),
    .mem_w_en_in  (mem_w_en_in),
    .alu_res_in   (alu_res_in),
    .val_r_m_in   (val_r_m_in),
    .dest_in      (dest_in),
    .freeze       (freeze),
    .wb_en_out    (wb_en_out),
    .mem_r_en_out (mem_r_en_out),
    .alu_res_out  (alu_res_out),
    .mem_data_out (mem_data_out),
    .dest_out     (dest_out)
  );

  mem_stage_module #(
    .WAIT_CYCLES (0)
  ) u_dut_zero (
    .clk          (clk),
    .rst          (rst),
    .wb_en_in     (z_wb_en_in),
    .mem_r_en_in  (z_mem_r_en_in),
    .mem_w_en_in  (z_mem_w_en_in),
    .alu_res_in   (z_alu_res_in),
    .val_r_m_in   (z_val_r_m_in),
    .dest_in      (z_dest_in),
    .freeze       (z_freeze),
    .wb_en_out    (z_wb_en_out),
    .mem_r_en_out (z_mem_r_en_out),
    .alu_res_out  (z_alu_res_out),
    .mem_data_out (z_mem_data_out),
    .dest_out     (z_dest_out)
  );

  exp_t q[$];
  exp_t zq[$];
  int   n_vec = 0;
  int   n_bad = 0;
  logic vld = 1'b0;
  logic z_vld = 1'b0;
  logic mon_fire = 1'b0, mon_frz = 1'b0, z_mon_fire = 1'b0;

  task automatic chk_out(input string name, input exp_t act, input exp_t exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got wb=%b rd=%b alu=%h data=%h dest=%h, expected wb=%b rd=%b alu=%h data=%h dest=%h",
               name, act.wb, act.rd, act.alu, act.data, act.dest,
               exp.wb, exp.rd, exp.alu, exp.data, exp.dest);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: outputs present a result the cycle after an accepted (unfrozen) request.
  always @(negedge clk) begin
    exp_t cur;
    cur = '{wb_en_out, mem_r_en_out, alu_res_out, mem_data_out, dest_out};
    if (mon_fire) begin
      if (q.size() == 0) chk_int("unexpected_output", 1, 0);
      else chk_out("result", cur, q.pop_front());
    end
    if (mon_frz) chk_int("bubble", int'({wb_en_out, mem_r_en_out}), 0);
    mon_fire = vld && !freeze && !rst;
    mon_frz  = freeze && !rst;
  end

  always @(negedge clk) begin
    exp_t cur;
    cur = '{z_wb_en_out, z_mem_r_en_out, z_alu_res_out, z_mem_data_out, z_dest_out};
    if (z_mon_fire) begin
      if (zq.size() == 0) chk_int("z_unexpected_output", 1, 0);
      else chk_out("z_result", cur, zq.pop_front());
    end
    z_mon_fire = z_vld && !z_freeze && !rst;
  end

  task automatic access(input logic wb, input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] dest,
                        input logic [31:0] exp_data, input int exp_frz);
    int frz;
    wb_en_in = wb; mem_r_en_in = rd; mem_w_en_in = wr;
    alu_res_in = addr; val_r_m_in = data; dest_in = dest;
    vld = 1'b1;
    q.push_back('{wb, rd, addr, exp_data, dest});
    frz = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!freeze) break;
      frz++;
      @(posedge clk); #1;
    end
    chk_int("freeze_cycles", frz, exp_frz);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    vld = 1'b0; wb_en_in = 1'b0; mem_r_en_in = 1'b0; mem_w_en_in = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic z_access(input logic wb, input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] dest,
                          input logic [31:0] exp_data);
    z_wb_en_in = wb; z_mem_r_en_in = rd; z_mem_w_en_in = wr;
    z_alu_res_in = addr; z_val_r_m_in = data; z_dest_in = dest;
    z_vld = 1'b1;
    zq.push_back('{wb, rd, addr, exp_data, dest});
    @(negedge clk);
    chk_int("z_freeze", int'(z_freeze), 0);
    @(posedge clk); #1;
    z_vld = 1'b0; z_wb_en_in = 1'b0; z_mem_r_en_in = 1'b0; z_mem_w_en_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    wb_en_in = 1'b0; mem_r_en_in = 1'b0; mem_w_en_in = 1'b0;
    alu_res_in = '0; val_r_m_in = '0; dest_in = '0;
    z_wb_en_in = 1'b0; z_mem_r_en_in = 1'b0; z_mem_w_en_in = 1'b0;
    z_alu_res_in = '0; z_val_r_m_in = '0; z_dest_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset_state", '{wb_en_out, mem_r_en_out, alu_res_out, mem_data_out, dest_out},
            '{1'b0, 1'b0, 32'd0, 32'd0, 4'd0});
    chk_int("reset_freeze", int'(freeze), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Store then load, default wait states
    access(1'b0, 1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 4'd7, 32'd0, 2);
    access(1'b1, 1'b1, 1'b0, 32'd1024, 32'd0, 4'd3, 32'hDEADBEEF, 2);
    idle();

    // ALU passthrough
    access(1'b1, 1'b0, 1'b0, 32'h12345678, 32'd0, 4'd5, 32'd0, 0);
    idle();

    // Out of range: one past the end, and below the base (wraps)
    access(1'b0, 1'b0, 1'b1, 32'd1280, 32'h55, 4'd0, 32'd0, 2);
    access(1'b1, 1'b1, 1'b0, 32'd1280, 32'd0, 4'd1, 32'd0, 2);
    access(1'b1, 1'b1, 1'b0, 32'd1020, 32'd0, 4'd2, 32'd0, 2);
    access(1'b1, 1'b1, 1'b0, 32'd1024, 32'd0, 4'd4, 32'hDEADBEEF, 2);
    idle();

    // Back-to-back stores, then read both back
    access(1'b0, 1'b0, 1'b1, 32'd1032, 32'hC0DE0001, 4'd0, 32'd0, 2);
    access(1'b0, 1'b0, 1'b1, 32'd1036, 32'hC0DE0002, 4'd0, 32'd0, 2);
    access(1'b1, 1'b1, 1'b0, 32'd1032, 32'd0, 4'd8, 32'hC0DE0001, 2);
    access(1'b1, 1'b1, 1'b0, 32'd1036, 32'd0, 4'd9, 32'hC0DE0002, 2);
    idle();

    // Both enables: store happens, load sees the old word
    access(1'b1, 1'b1, 1'b1, 32'd1036, 32'h0000BEEF, 4'd10, 32'hC0DE0002, 2);
    access(1'b1, 1'b1, 1'b0, 32'd1036, 32'd0, 4'd11, 32'h0000BEEF, 2);
    idle();

    // Reset in the second frozen cycle of a store
    access(1'b0, 1'b0, 1'b1, 32'd1028, 32'h11112222, 4'd9, 32'd0, 2);
    idle();
    wb_en_in = 1'b0; mem_r_en_in = 1'b0; mem_w_en_in = 1'b1;
    alu_res_in = 32'd1028; val_r_m_in = 32'h0000AAAA; dest_in = 4'd9;
    @(negedge clk);
    chk_int("abort_freeze_1", int'(freeze), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; mem_w_en_in = 1'b0;
    @(negedge clk);
    chk_out("reset_mid_store", '{wb_en_out, mem_r_en_out, alu_res_out, mem_data_out, dest_out},
            '{1'b0, 1'b0, 32'd0, 32'd0, 4'd0});
    @(posedge clk); #1;
    access(1'b1, 1'b1, 1'b0, 32'd1028, 32'd0, 4'd12, 32'h11112222, 2);
    idle();

    // Zero wait states
    z_access(1'b0, 1'b0, 1'b1, 32'd1024, 32'h0BADF00D, 4'd0, 32'd0);
    z_access(1'b1, 1'b1, 1'b0, 32'd1024, 32'd0, 4'd6, 32'h0BADF00D);
    @(posedge clk); #1;
    @(posedge clk); #1;

    chk_int("scoreboard_drain", q.size(), 0);
    chk_int("z_scoreboard_drain", zq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_stage_module.md
# mem_stage_module

Memory stage of the five-stage ARM pipeline. It consumes the registered outputs of the execute stage and performs data-memory loads and stores against an internal word-addressed data memory with configurable wait states. While an access is in progress it asserts `freeze` to stall upstream stages. It registers the results into the MEM/WB pipeline register feeding write-back.

## Interface
Parameters:
- `DEPTH_WORDS`, 64: data memory depth in 32-bit words.
- `BASE_ADDR`, 1024: byte address mapped to word 0.
- `WAIT_CYCLES`, 2: extra cycles per access. Legal range is 0..15.

Ports:
- `clk` input 1: single clock. All state updates on the rising edge.
- `rst` input 1: reset. It is synchronous and active-high.
- `wb_en_in` input 1: write-back enable from the EXE stage register.
- `mem_r_en_in` input 1: load request.
- `mem_w_en_in` input 1: store request.
- `alu_res_in` input 32: effective byte address for memory ops; otherwise the ALU result.
- `val_r_m_in` input 32: store data.
- `dest_in` input 4: destination register index.
- `freeze` output 1: stall request to hazard/upstream logic. It is combinational.
- `wb_en_out` output 1: registered write-back enable.
- `mem_r_en_out` output 1: registered load flag, which selects `mem_data_out` in WB.
- `alu_res_out` output 32: registered ALU result.
- `mem_data_out` output 32: registered load data.
- `dest_out` output 4: registered destination.

## Operation
- Access request: `acc = mem_r_en_in | mem_w_en_in`.
- Word index: `idx = (alu_res_in - BASE_ADDR) >> 2`, computed 32-bit unsigned.
  - The low two address bits are ignored.
  - If `idx >= DEPTH_WORDS` (including underflow wrap), the address is out of range.
  - An out-of-range store is dropped and an out-of-range load returns 0. Latency is unchanged.
- FSM with states IDLE and WAIT, plus a 4-bit counter `cnt`:
  - IDLE, `acc` and `WAIT_CYCLES>0`: go to WAIT with `cnt=1`.
  - IDLE, `acc` and `WAIT_CYCLES==0`: complete this cycle and stay in IDLE.
  - IDLE, no `acc`: stay in IDLE.
  - WAIT, `cnt==WAIT_CYCLES`: complete this cycle, go to IDLE, set `cnt=0`.
  - WAIT, otherwise: `cnt=cnt+1`.
  - WAIT, `acc` dropped (illegal): return to IDLE with `cnt=0`, no write.
- Freeze: `freeze = acc & ~complete`, where `complete = acc & (WAIT_CYCLES==0 | (state==WAIT & cnt==WAIT_CYCLES))`.
- Store: the memory word is written on the completing edge only, never during wait cycles.
- Load: the memory is read at `idx`, and the data is captured into `mem_data_out` on the completing edge.
- Both read and write enables set: perform the store; `mem_data_out` gets the pre-write contents.
- MEM/WB register, each edge:
  - If `freeze` is high: load a bubble (`wb_en_out=0`, `mem_r_en_out=0`, other fields don't-care). This prevents duplicate write-back.
  - Otherwise: load `wb_en_in`, `mem_r_en_in`, `alu_res_in`, `dest_in`, and the read data (0 when not a load).
- Non-memory instructions pass through with one-cycle latency and never assert `freeze`.

## Timing
- Reset values:
  - `state=IDLE`, `cnt=0`.
  - `wb_en_out=0`, `mem_r_en_out=0`, `alu_res_out=0`, `mem_data_out=0`, `dest_out=0`.
  - `freeze` follows its equation, so it is 0 when there is no request.
  - Memory contents are not cleared by reset.
- Access latency: with the access presented in cycle T, `freeze` is high in cycles T..T+WAIT_CYCLES-1 and low in T+WAIT_CYCLES. The result is visible on the outputs in cycle T+WAIT_CYCLES+1.
- Upstream obligation: the EXE stage register holds all inputs stable while `freeze`=1.
- Back-to-back accesses: the next access may be presented in T+WAIT_CYCLES+1 and starts from IDLE with no dead cycle.
- Reset mid-access: `rst` wins at the edge.
  - State returns to IDLE and the outputs clear.
  - A pending store is not performed.
- Counter never exceeds `WAIT_CYCLES`. No wrap is possible within the legal range.

## Test plan
- **Store then load, default wait states:** store `alu_res_in=1024`, `val_r_m_in=0xDEADBEEF`, then load from 1024 with `dest_in=3`.
  - Each access: `freeze` high for exactly 2 cycles.
  - After the load: `mem_data_out=0xDEADBEEF`, `dest_out=3`, `mem_r_en_out=1`.
  - Bubbles (`wb_en_out=0`) during the frozen cycles.
- **ALU passthrough:** `wb_en_in=1`, `alu_res_in=0x12345678`, `dest_in=5`, no memory enables.
  - `freeze` stays 0.
  - Next cycle: `alu_res_out=0x12345678`, `wb_en_out=1`, `mem_r_en_out=0`.
- **Out of range:** store 0x55 to address 1024+4*64, then load from the same address, then load from 1020.
  - Normal freeze timing on all three.
  - Both loads return 0.
  - Word 0 unchanged.
- **Zero wait states (`WAIT_CYCLES=0`):** load.
  - `freeze` never asserts.
  - Data appears one cycle later.
- **Reset mid-store:** assert `rst` in the second frozen cycle of a store of 0xAAAA to 1028, then load 1028.
  - All outputs are 0 after the reset edge.
  - The later load returns the prior contents, not 0xAAAA.
- **Back-to-back stores:** stores to 1032 and 1036 presented consecutively.
  - `freeze` pattern is 1,1,0,1,1,0.
  - Both words are written.
